// File: rtl/fpro_bridge_pkg.sv
// Shared definitions for the MCS IO-bus to FPro-bus bridge.
// Contents:
//   state_t      - bridge sequencer states
//   BUS_ERR_DATA - read data returned on an aborted read
//   WIN_MSB/LSB  - address bits compared against the bridge window base
package fpro_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;
  localparam int          WIN_MSB      = 31;
  localparam int          WIN_LSB      = 24;

endpackage

// File: rtl/fpro_region_decode.sv
// Combinational region decoder for the bridge window.
// Ports:
//   address - upper address bits: window bits plus the region index bits below them
//   hit     - address is inside the window and names an existing region
//   idx     - region index taken from the bits just below the window
//   cs      - one-hot region select, all zero on a miss
module fpro_region_decode
  import fpro_bridge_pkg::*;
#(
  parameter logic [31:0] BRG_BASE = 32'hC000_0000,
  parameter int          NUM_CS   = 2,
  parameter int          CS_W     = $clog2(NUM_CS)
) (
  input  logic [WIN_MSB:WIN_LSB-CS_W] address,
  output logic                        hit,
  output logic [CS_W-1:0]             idx,
  output logic [NUM_CS-1:0]           cs
);

  logic win_match;

  // When NUM_CS is not a power of two the top index codes name no region
  // and must be reported as a miss.
  always_comb begin
    win_match = (address[WIN_MSB:WIN_LSB] == BRG_BASE[WIN_MSB:WIN_LSB]);
    idx       = address[WIN_LSB-1 -: CS_W];
    hit       = win_match && (int'(idx) < NUM_CS);
    cs        = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      cs[i] = hit && (int'(idx) == i);
    end
  end

endmodule

// File: rtl/fpro_multi_bridge.sv
// MicroBlaze MCS IO-bus to FPro-bus bridge with multiple chip-selects,
// per-region ready handshake, bus timeout, byte enables and error pulse.
// Ports:
//   clk, reset_n      - system clock, asynchronous active-low reset
//   io_*              - MCS IO-bus side (strobes, byte enables, address, data, ready)
//   fp_cs             - one-hot region select, held from ACCESS through WAIT
//   fp_rd, fp_wr      - one-cycle strobes in ACCESS
//   fp_be, fp_addr,
//   fp_wr_data        - request fields latched at the MCS strobe
//   fp_rd_data        - packed per-region read data, region i at [32*i +: 32]
//   fp_ready          - per-region completion; tie high for zero-wait slaves
//   bus_err           - pulses together with io_ready when an access is aborted
module fpro_multi_bridge
  import fpro_bridge_pkg::*;
#(
  parameter logic [31:0] BRG_BASE = 32'hC000_0000,
  parameter int          NUM_CS   = 2,
  parameter int          ADDR_W   = 21,
  parameter int          TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   io_addr_strobe,
  input  logic                   io_read_strobe,
  input  logic                   io_write_strobe,
  input  logic [3:0]             io_byte_enable,
  input  logic [31:0]            io_address,
  input  logic [31:0]            io_write_data,
  output logic [31:0]            io_read_data,
  output logic                   io_ready,
  output logic [NUM_CS-1:0]      fp_cs,
  output logic                   fp_rd,
  output logic                   fp_wr,
  output logic [3:0]             fp_be,
  output logic [ADDR_W-1:0]      fp_addr,
  output logic [31:0]            fp_wr_data,
  input  logic [NUM_CS*32-1:0]   fp_rd_data,
  input  logic [NUM_CS-1:0]      fp_ready,
  output logic                   bus_err
);

  localparam int                CS_W     = $clog2(NUM_CS);
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  if (NUM_CS < 2) begin : g_bad_num_cs
    $error("fpro_multi_bridge: NUM_CS must be at least 2");
  end
  if (ADDR_W + 2 + CS_W > 24) begin : g_bad_addr_w
    $error("fpro_multi_bridge: ADDR_W+2+CS_W must not exceed 24");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fpro_multi_bridge: TIMEOUT must be at least 1");
  end

  state_t              state;
  state_t              next_state;
  logic                dec_hit;
  logic [CS_W-1:0]     dec_idx;
  logic [NUM_CS-1:0]   dec_cs;
  logic                req_ok;
  logic [CS_W-1:0]     idx_q;
  logic [NUM_CS-1:0]   cs_q;
  logic                rd_q;
  logic                wr_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt;
  logic [31:0]         rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          be_q;
  logic [31:0]         wdata_q;
  logic                ready_sel;
  logic [31:0]         rd_sel;
  logic                unused_addr;

  fpro_region_decode #(
    .BRG_BASE (BRG_BASE),
    .NUM_CS   (NUM_CS),
    .CS_W     (CS_W)
  ) u_decode (
    .address (io_address[WIN_MSB:WIN_LSB-CS_W]),
    .hit     (dec_hit),
    .idx     (dec_idx),
    .cs      (dec_cs)
  );

  // Exactly one of read/write must qualify the strobe; anything else is an error.
  assign req_ok = io_read_strobe ^ io_write_strobe;

  // The byte-offset bits and any bits between fp_addr and the region index
  // have no meaning on the FPro side.
  assign unused_addr = ^io_address;

  // Route the addressed region's ready and read data.
  always_comb begin
    ready_sel = 1'b0;
    rd_sel    = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(idx_q) == i) begin
        ready_sel = fp_ready[i];
        rd_sel    = fp_rd_data[i*32 +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Ready is checked before the timeout so a slave that
  // answers on the last allowed cycle still completes normally.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (io_addr_strobe) begin
          next_state = (dec_hit && req_ok) ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        next_state = ready_sel ? DONE : WAIT;
      end
      WAIT: begin
        if (ready_sel || (cnt == CNT_LAST)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs decoded from state; only the ACCESS and WAIT cycles drive the slaves.
  always_comb begin
    fp_cs    = '0;
    fp_rd    = 1'b0;
    fp_wr    = 1'b0;
    io_ready = 1'b0;
    bus_err  = 1'b0;
    case (state)
      ACCESS: begin
        fp_cs = cs_q;
        fp_rd = rd_q;
        fp_wr = wr_q;
      end
      WAIT: begin
        fp_cs = cs_q;
      end
      DONE: begin
        io_ready = 1'b1;
        bus_err  = err_q;
      end
      default: begin
      end
    endcase
  end

  // Request latches, timeout counter and the completion result. The counter
  // counts WAIT cycles already spent, so TIMEOUT wait cycles end in an abort.
  // io_read_data is only written on the way into DONE and otherwise holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cs_q    <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_addr_strobe) begin
            addr_q  <= io_address[ADDR_W+1:2];
            be_q    <= io_byte_enable;
            wdata_q <= io_write_data;
            rd_q    <= io_read_strobe;
            wr_q    <= io_write_strobe;
            cs_q    <= dec_cs;
            idx_q   <= dec_idx;
            cnt     <= '0;
            if (dec_hit && req_ok) begin
              err_q <= 1'b0;
            end else begin
              err_q   <= 1'b1;
              rdata_q <= io_read_strobe ? BUS_ERR_DATA : 32'h0;
            end
          end
        end
        ACCESS: begin
          cnt <= '0;
          if (ready_sel) begin
            rdata_q <= rd_q ? rd_sel : 32'h0;
          end
        end
        WAIT: begin
          if (ready_sel) begin
            rdata_q <= rd_q ? rd_sel : 32'h0;
          end else if (cnt == CNT_LAST) begin
            err_q   <= 1'b1;
            rdata_q <= rd_q ? BUS_ERR_DATA : 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_read_data = rdata_q;
  assign fp_addr      = addr_q;
  assign fp_be        = be_q;
  assign fp_wr_data   = wdata_q;

endmodule
